// File: rtl/nes_input_pkg.sv
// Shared constants for the PS/2 keyboard to NES joypad path: button indices,
// set-2 scan codes, decoder states and the key-to-button lookup.
package nes_input_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_X      = 8'h22;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_e;

    // One-hot button mask for a scan code; zero when the code is unmapped.
    function automatic logic [7:0] key_mask(input logic [7:0] code);
        logic [7:0] m;
        m = '0;
        case (code)
            SC_X:      m[BTN_A]      = 1'b1;
            SC_Z:      m[BTN_B]      = 1'b1;
            SC_RSHIFT: m[BTN_SELECT] = 1'b1;
            SC_ENTER:  m[BTN_START]  = 1'b1;
            SC_UP:     m[BTN_UP]     = 1'b1;
            SC_DOWN:   m[BTN_DOWN]   = 1'b1;
            SC_LEFT:   m[BTN_LEFT]   = 1'b1;
            SC_RIGHT:  m[BTN_RIGHT]  = 1'b1;
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_joypad_ctrl_if.sv
// Keyboard-byte input, CPU $4016 access and joypad status outputs.
interface ps2_joypad_ctrl_if;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       strobe_wr;
    logic       strobe_data;
    logic       rd;
    logic       joy_d0;
    logic [7:0] buttons;
    logic       changed;

    modport master (
        output scan_valid, scan_code, strobe_wr, strobe_data, rd,
        input  joy_d0, buttons, changed
    );

    modport slave (
        input  scan_valid, scan_code, strobe_wr, strobe_data, rd,
        output joy_d0, buttons, changed
    );
endinterface

// File: rtl/ps2_scan_decoder.sv
// Make/break prefix FSM with a prefix timeout; tracks the raw held state of
// the eight mapped keys.
module ps2_scan_decoder
    import nes_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic [7:0] raw_buttons
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    dec_state_e    state_q, state_d;
    logic [7:0]    raw_q, raw_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    key;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            raw_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            raw_q   <= raw_d;
            cnt_q   <= cnt_d;
        end
    end

    // A byte always wins over the timeout, so it is decoded in the current state.
    always_comb begin
        state_d = state_q;
        raw_d   = raw_q;
        cnt_d   = cnt_q;
        key     = key_mask(scan_code);
        if (scan_valid) begin
            cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (scan_code == SC_BREAK)    state_d = BRK;
                    else if (scan_code == SC_EXT) state_d = EXT;
                    else                          raw_d   = raw_q | key;
                end
                EXT: begin
                    if (scan_code == SC_BREAK) state_d = EXT_BRK;
                    else begin
                        raw_d   = raw_q | key;
                        state_d = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    raw_d   = raw_q & ~key;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == TMO_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign raw_buttons = raw_q;

endmodule

// File: rtl/ps2_joypad_ctrl.sv
// PS/2 keys to NES controller: SOCD masking, change pulse and the $4016
// strobe / serial-read shift register.
module ps2_joypad_ctrl
    import nes_input_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter bit MASK_SOCD      = 1'b1
) (
    input  logic              Clk,
    input  logic              reset_n,
    ps2_joypad_ctrl_if.slave  jp
);

    logic [7:0] raw;
    logic [7:0] masked;
    logic [7:0] btn_q;
    logic       changed_q;
    logic       strobe_q;
    logic [7:0] shift_q;

    ps2_scan_decoder #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dec (
        .Clk         (Clk),
        .reset_n     (reset_n),
        .scan_valid  (jp.scan_valid),
        .scan_code   (jp.scan_code),
        .raw_buttons (raw)
    );

    // Masking only affects what is reported; raw keeps both keys of a pair.
    always_comb begin
        masked = raw;
        if (MASK_SOCD) begin
            if (raw[BTN_UP] && raw[BTN_DOWN]) begin
                masked[BTN_UP]   = 1'b0;
                masked[BTN_DOWN] = 1'b0;
            end
            if (raw[BTN_LEFT] && raw[BTN_RIGHT]) begin
                masked[BTN_LEFT]  = 1'b0;
                masked[BTN_RIGHT] = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            btn_q     <= masked;
            changed_q <= (masked != btn_q);
        end
    end

    // strobe_wr outranks rd; a live strobe reloads every edge.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            shift_q  <= '0;
        end else if (jp.strobe_wr) begin
            strobe_q <= jp.strobe_data;
            shift_q  <= masked;
        end else if (strobe_q) begin
            shift_q  <= masked;
        end else if (jp.rd) begin
            shift_q  <= {1'b1, shift_q[7:1]};
        end
    end

    assign jp.buttons = masked;
    assign jp.changed = changed_q;
    assign jp.joy_d0  = shift_q[0];

endmodule

// File: tb/tb_ps2_joypad_ctrl.sv
// Directed bench for ps2_joypad_ctrl: decoder, masking, change pulse,
// timeout and the $4016 strobe/read sequence.
module tb_ps2_joypad_ctrl;
    import nes_input_pkg::*;

    logic Clk;
    logic reset_n;
    int   checks;
    int   failures;

    ps2_joypad_ctrl_if jif ();
    ps2_joypad_ctrl_if jif0 ();

    ps2_joypad_ctrl #(.TIMEOUT_CYCLES(16), .MASK_SOCD(1'b1)) u_dut (
        .Clk(Clk), .reset_n(reset_n), .jp(jif.slave)
    );

    // Unmasked twin sharing the same stimulus.
    ps2_joypad_ctrl #(.TIMEOUT_CYCLES(16), .MASK_SOCD(1'b0)) u_dut0 (
        .Clk(Clk), .reset_n(reset_n), .jp(jif0.slave)
    );

    assign jif0.scan_valid  = jif.scan_valid;
    assign jif0.scan_code   = jif.scan_code;
    assign jif0.strobe_wr   = jif.strobe_wr;
    assign jif0.strobe_data = jif.strobe_data;
    assign jif0.rd          = jif.rd;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] code);
        jif.scan_valid = 1'b1;
        jif.scan_code  = code;
        @(negedge Clk);
        jif.scan_valid = 1'b0;
        jif.scan_code  = 8'h00;
    endtask

    task automatic strobe(input logic d);
        jif.strobe_wr   = 1'b1;
        jif.strobe_data = d;
        @(negedge Clk);
        jif.strobe_wr   = 1'b0;
        jif.strobe_data = 1'b0;
    endtask

    task automatic rd_pulse();
        jif.rd = 1'b1;
        @(negedge Clk);
        jif.rd = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_seq;
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        jif.scan_valid  = 1'b0;
        jif.scan_code   = 8'h00;
        jif.strobe_wr   = 1'b0;
        jif.strobe_data = 1'b0;
        jif.rd          = 1'b0;
        step(3);
        chk("rst_buttons", jif.buttons, 8'h00);
        chk("rst_joy_d0", {7'd0, jif.joy_d0}, 8'h00);
        chk("rst_changed", {7'd0, jif.changed}, 8'h00);
        reset_n = 1'b1;
        step(2);

        // reset in the middle of a break prefix
        send(SC_X);
        chk("pre_rst_A", jif.buttons, 8'h01);
        send(SC_BREAK);
        reset_n = 1'b0;
        #1;
        chk("midrst_buttons", jif.buttons, 8'h00);
        chk("midrst_changed", {7'd0, jif.changed}, 8'h00);
        step(1);
        reset_n = 1'b1;
        step(1);
        send(SC_X);
        chk("post_rst_make", jif.buttons, 8'h01);
        chk("changed_delay", {7'd0, jif.changed}, 8'h00);
        step(1);
        chk("changed_A", {7'd0, jif.changed}, 8'h01);
        step(1);
        chk("changed_one_cycle", {7'd0, jif.changed}, 8'h00);

        // make / break and typematic repeat
        send(SC_ENTER);
        chk("A_start", jif.buttons, 8'h09);
        step(1);
        chk("changed_start", {7'd0, jif.changed}, 8'h01);
        send(SC_BREAK);
        send(SC_X);
        chk("brk_A", jif.buttons, 8'h08);
        step(1);
        chk("changed_brk", {7'd0, jif.changed}, 8'h01);
        send(SC_X);
        chk("remake_A", jif.buttons, 8'h09);
        step(1);
        chk("changed_remake", {7'd0, jif.changed}, 8'h01);
        send(SC_X);
        chk("typematic_A", jif.buttons, 8'h09);
        step(1);
        chk("changed_typematic", {7'd0, jif.changed}, 8'h00);
        send(SC_E1);
        send(8'h33);
        chk("ignored_codes", jif.buttons, 8'h09);
        send(SC_BREAK); send(SC_X);
        send(SC_BREAK); send(SC_ENTER);
        chk("cleared", jif.buttons, 8'h00);
        step(2);

        // opposing directions
        send(SC_EXT); send(SC_UP);
        chk("ext_up", jif.buttons, 8'h10);
        send(SC_DOWN);
        chk("socd_masked", jif.buttons, 8'h00);
        chk("socd_unmasked", jif0.buttons, 8'h30);
        send(SC_EXT); send(SC_BREAK); send(SC_UP);
        chk("socd_restore", jif.buttons, 8'h20);
        chk("socd_restore_nm", jif0.buttons, 8'h20);
        send(SC_BREAK); send(SC_DOWN);
        chk("dirs_clear", jif.buttons, 8'h00);

        // A + Right, latch, read out ten bits
        send(SC_X); send(SC_EXT); send(SC_RIGHT);
        chk("A_right", jif.buttons, 8'h81);
        strobe(1'b1);
        strobe(1'b0);
        exp_seq = 10'b11_1000_0001;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("read_bit%0d", i), {7'd0, jif.joy_d0}, {7'd0, exp_seq[i]});
            rd_pulse();
        end
        send(SC_BREAK); send(SC_X);
        send(SC_EXT); send(SC_BREAK); send(SC_RIGHT);
        chk("clear_AR", jif.buttons, 8'h00);

        // break prefix survives a short gap, times out after a long one
        send(SC_Z);
        chk("B_set", jif.buttons, 8'h02);
        send(SC_BREAK);
        step(4);
        send(SC_Z);
        chk("brk_short_gap", jif.buttons, 8'h00);
        send(SC_Z);
        send(SC_BREAK); send(SC_Z);
        chk("B_cleared", jif.buttons, 8'h00);
        send(SC_BREAK);
        step(20);
        send(SC_Z);
        chk("timeout_make", jif.buttons, 8'h02);
        send(SC_BREAK); send(SC_Z);

        // live strobe, reload ordering and strobe_wr-over-rd
        strobe(1'b1);
        chk("strobe_live0", {7'd0, jif.joy_d0}, 8'h00);
        send(SC_X);
        chk("reload_old_btns", {7'd0, jif.joy_d0}, 8'h00);
        step(1);
        chk("strobe_follow", {7'd0, jif.joy_d0}, 8'h01);
        rd_pulse();
        chk("strobe_rd_ignored", {7'd0, jif.joy_d0}, 8'h01);
        jif.strobe_wr   = 1'b1;
        jif.strobe_data = 1'b0;
        jif.rd          = 1'b1;
        step(1);
        jif.strobe_wr   = 1'b0;
        jif.rd          = 1'b0;
        chk("wr_beats_rd", {7'd0, jif.joy_d0}, 8'h01);
        rd_pulse();
        chk("shift_after_latch", {7'd0, jif.joy_d0}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_joypad_ctrl.md
# ps2_joypad_ctrl

Converts the byte stream from the PS/2 keyboard receiver into an NES standard-controller button state, then serves it to the CPU through the $4016 strobe/serial-read protocol. It sits between the keyboard front end (scan-code bytes) and the CPU I/O decode (joypad 1 port). It owns:
- the make/break prefix state machine;
- the key-to-button map;
- opposing-direction masking;
- the 8-bit parallel-load/serial-out joypad shift register.

## Interface
Parameters:
- TIMEOUT_CYCLES, 2**20: Clk cycles a prefix state may wait for its follow-up byte before returning to IDLE.
- MASK_SOCD, 1: when 1, the reported Up+Down and Left+Right pairs read as 0 if both keys in the pair are held.

Ports:
- Clk  in  1  system clock; only clock in the block.
- reset_n  in  1  asynchronous, active-low reset.
- scan_valid  in  1  one-cycle pulse; scan_code is valid.
- scan_code  in  8  PS/2 set-2 byte.
- strobe_wr  in  1  CPU write to $4016 (one-cycle pulse).
- strobe_data  in  1  bit 0 of the write data.
- rd  in  1  CPU read of $4016 (one-cycle pulse).
- joy_d0  out  1  serial button bit, equal to shift_reg[0].
- buttons  out  8  held-key state after masking. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- changed  out  1  one-cycle pulse, the cycle after buttons changes.

## Operation
Decoder states and transitions:
- IDLE:
  - F0 goes to BRK.
  - E0 goes to EXT.
  - E1 is discarded and stays in IDLE.
  - A mapped code sets its bit. Any other code is ignored.
- EXT:
  - F0 goes to EXT_BRK.
  - A mapped code sets its bit and goes to IDLE.
  - Any other code goes to IDLE.
- BRK / EXT_BRK:
  - A mapped code clears its bit and goes to IDLE.
  - Any other code goes to IDLE.

Key map:
- X 22 maps to A.
- Z 1A maps to B.
- RShift 59 maps to Select.
- Enter 5A maps to Start.
- Arrows map 75 to Up, 72 to Down, 6B to Left and 74 to Right. These are accepted with or without the E0 prefix.

Other behaviour:
- Typematic repeat of a make code rewrites an already-set bit. No change occurs and changed does not pulse.
- Prefix timeout: a counter clears on every scan_valid. In any state other than IDLE, reaching TIMEOUT_CYCLES-1 forces IDLE. A lost break therefore never latches onto a later byte.
- SOCD masking applies only to the reported buttons. The raw held bits stay exact, so releasing one key of a pair restores the other.

Joypad shift register (8 bits):
- Strobe register: loaded from strobe_data on strobe_wr.
- When strobe_wr=1, shift_reg loads buttons at that edge. This applies for either strobe_data value, so writing 0 performs the final latch.
- While strobe=1, shift_reg reloads every edge and rd is ignored.
- While strobe=0, rd shifts right at the edge, filling with 1. After 8 reads joy_d0 reads 1 indefinitely.

Reset values:
- Decoder: state IDLE, raw held bits 00, timeout counter 0.
- Joypad side: strobe 0, shift_reg 00.
- Outputs: buttons 00, joy_d0 0, changed 0.
- A reset mid-prefix or mid-read discards all partial state.

## Timing
- scan_valid at edge n: buttons updates at edge n (visible in cycle n+1). changed is high during cycle n+2.
- joy_d0 is combinational from shift_reg[0] and has no read latency. rd in cycle k presents the current bit; the next bit appears after edge k.
- Simultaneous scan_valid with a strobe reload: the reload takes buttons as it was before that edge.
- Simultaneous strobe_wr with rd: strobe_wr wins and rd is dropped.
- scan_valid arriving on the timeout edge: the byte is processed in the current state and the timeout counter clears.

## Structure
- Package nes_input_pkg holds:
  - button index constants (BTN_A … BTN_RIGHT);
  - scan-code localparams (SC_BREAK=F0, SC_EXT=E0, SC_E1=E1 and the eight key codes);
  - the decoder state enum {IDLE, EXT, BRK, EXT_BRK}.
- Sub-module ps2_scan_decoder holds the FSM, timeout counter and raw held bits, and outputs the raw 8-bit state.
- The top level holds:
  - SOCD masking;
  - the changed pulse;
  - the strobe and shift register.

## Test plan
- Reset with reset_n low mid-sequence (after F0) -> all outputs 0. Then send byte 22 -> buttons=01, not a break.
- Send 22, then 5A, then F0 22 -> buttons goes 01, then 09, then 08. changed pulses three times. Sending 22 again twice pulses changed only once.
- Send E0 75, then 72 (no prefix) -> raw Up and Down both held, so buttons=00 with MASK_SOCD=1 or 30 with MASK_SOCD=0. Then send E0 F0 75 -> buttons=20.
- Hold A and Right (buttons=81). Write strobe 1 then 0, then issue 10 rd pulses -> joy_d0 reads 1,0,0,0,0,0,0,1,1,1.
- Send F0, wait TIMEOUT_CYCLES (use a small parameter, e.g. 16), then send 1A -> B is set, not cleared (buttons=02).
- While strobe=1 send 22 and pulse rd -> joy_d0 follows buttons bit 0 and rd does not shift. strobe_wr and rd in the same cycle -> shift_reg is reloaded, not shifted.
